mem_cmd_arbiter: RTL

- Two-requester arbiter sharing the single wishbone-master command/response interface (cmd_stb/cmd_word/cmd_busy/rsp_stb/rsp_word) of the multi-cycle RISC-V core.
- Requester 0 is instruction fetch; requester 1 is data load/store from the controller.
- Latches each request, grants round-robin, issues one outstanding command to the master and routes the response back to its owner.
- Includes a response watchdog so the core's memory states cannot hang forever.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/arb_req_slot.sv | 36 +++
 rtl/mem_cmd_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core's memory command/response bus.
// Word layout: [33:32] opcode/status, [31:0] address/data.
package mem_bus_pkg;

  localparam int WORD_W = 34;
  localparam int OP_HI  = 33;
  localparam int OP_LO  = 32;

  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_req_slot.sv
// One requester's capture register, pending flag and busy flag.
// Busy is registered from the next-cycle pending/in-flight view.
module arb_req_slot #(
  parameter int WORD_W = mem_bus_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_stb,
  input  logic [WORD_W-1:0] cmd_word,
  input  logic              clr,
  input  logic              inflight_nx,
  output logic              pend,
  output logic [WORD_W-1:0] word,
  output logic              busy
);

  logic take;
  logic pend_nx;

  // A strobe while busy is dropped so the latched word stays intact.
  assign take    = cmd_stb & ~busy;
  assign pend_nx = take | (pend & ~clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      busy <= 1'b0;
      word <= '0;
    end else begin
      pend <= pend_nx;
      busy <= pend_nx | inflight_nx;
      if (take) word <= cmd_word;
    end
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Round-robin arbiter for fetch (port 0) and data (port 1) onto one
// memory master, one command in flight, with a response watchdog.
module mem_cmd_arbiter #(
  parameter int WORD_W  = mem_bus_pkg::WORD_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_cmd_stb,
  input  logic [WORD_W-1:0] s0_cmd_word,
  output logic              s0_cmd_busy,
  output logic              s0_rsp_stb,
  output logic [WORD_W-1:0] s0_rsp_word,
  input  logic              s1_cmd_stb,
  input  logic [WORD_W-1:0] s1_cmd_word,
  output logic              s1_cmd_busy,
  output logic              s1_rsp_stb,
  output logic [WORD_W-1:0] s1_rsp_word,
  output logic              m_cmd_stb,
  output logic [WORD_W-1:0] m_cmd_word,
  input  logic              m_cmd_busy,
  input  logic              m_rsp_stb,
  input  logic [WORD_W-1:0] m_rsp_word,
  output logic              timeout_err
);
  import mem_bus_pkg::*;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam logic [WORD_W-1:0] TO_WORD =
    {RSP_TIMEOUT, {(WORD_W-2){1'b0}}};

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;

  logic [1:0] pend, busy, clr, infl_d;
  logic [1:0] rsp_set, rsp_q;
  logic [WORD_W-1:0] word0, word1;
  logic [WORD_W-1:0] rword0_q, rword1_q;
  logic fire;

  arb_req_slot #(.WORD_W(WORD_W)) u_slot0 (
    .clk         (clk),
    .reset       (reset),
    .cmd_stb     (s0_cmd_stb),
    .cmd_word    (s0_cmd_word),
    .clr         (clr[0]),
    .inflight_nx (infl_d[0]),
    .pend        (pend[0]),
    .word        (word0),
    .busy        (busy[0])
  );

  arb_req_slot #(.WORD_W(WORD_W)) u_slot1 (
    .clk         (clk),
    .reset       (reset),
    .cmd_stb     (s1_cmd_stb),
    .cmd_word    (s1_cmd_word),
    .clr         (clr[1]),
    .inflight_nx (infl_d[1]),
    .pend        (pend[1]),
    .word        (word1),
    .busy        (busy[1])
  );

  assign s0_cmd_busy = busy[0];
  assign s1_cmd_busy = busy[1];

  assign infl_d[0] = (state_d == ST_WAIT) & ~owner_d;
  assign infl_d[1] = (state_d == ST_WAIT) &  owner_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wd_d       = wd_q;
    wd_inc     = wd_q + 1'b1;
    clr        = 2'b00;
    rsp_set    = 2'b00;
    fire       = 1'b0;
    m_cmd_stb  = 1'b0;
    m_cmd_word = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          owner_d = (&pend) ? ~last_q : pend[1];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!m_cmd_busy) begin
          m_cmd_stb      = 1'b1;
          m_cmd_word     = owner_q ? word1 : word0;
          clr[owner_q]   = 1'b1;
          last_d         = owner_q;
          wd_d           = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_d = wd_inc;
        // A response on the expiry cycle still wins over the watchdog.
        if (m_rsp_stb) begin
          rsp_set[owner_q] = 1'b1;
          state_d          = ST_IDLE;
        end else if (TIMEOUT != 0 && wd_inc == TO_LIM) begin
          fire    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q    <= 2'b00;
      rword0_q <= '0;
      rword1_q <= '0;
    end else begin
      rsp_q <= rsp_set;
      if (rsp_set[0])            rword0_q <= m_rsp_word;
      else if (fire && !owner_q) rword0_q <= TO_WORD;
      if (rsp_set[1])            rword1_q <= m_rsp_word;
      else if (fire && owner_q)  rword1_q <= TO_WORD;
    end
  end

  assign timeout_err = fire;

  assign s0_rsp_stb  = rsp_q[0] | (fire & ~owner_q);
  assign s1_rsp_stb  = rsp_q[1] | (fire &  owner_q);
  assign s0_rsp_word = (fire & ~owner_q) ? TO_WORD : rword0_q;
  assign s1_rsp_word = (fire &  owner_q) ? TO_WORD : rword1_q;

endmodule
